// File: rtl/bus_dev_port.sv
// Per-device bus port: TX FIFO toward the bus, destination-filtered RX FIFO from the bus.
// Latency: 1 cycle from accepted write/push to visible head; heads and flags are registered-state only.
// Backpressure: a full FIFO drops new entries unless the head is consumed in the same cycle; RX drops set a sticky overflow flag.

// Generic first-word-fall-through circular FIFO with an occupancy counter.
// Latency: an accepted write is visible at the head after the next rising edge.
// Backpressure: a write while full is dropped unless a read is accepted in the same cycle.
module bus_dev_port_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [W-1:0]             wdata,
    input  logic                     rd,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     wr_ok
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_ok;

    // Accept rules: a read needs data; a write needs room, or a read freeing a slot this cycle.
    always_comb begin
        rd_ok    = rd && (count_q != '0);
        wr_ok    = wr && ((count_q != CW'(DEPTH)) || rd_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and occupancy registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left uncleared by reset; the zeroed head output hides stale data.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
endmodule

// Device port adapter between one driver/monitor and one bus slot.
// Latency: tx_wr -> pndng/D_pop and push -> rx_data are 1 cycle; rx_ovf/misroute_cnt update on the push edge.
// Backpressure: tx_full/rx_count report occupancy; overflowing writes are dropped, RX drops latch rx_ovf.
module bus_dev_port #(
    parameter int         pckg_sz   = 20,
    parameter int         depth     = 8,
    parameter logic [7:0] dev_id    = 8'd0,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tx_wr,
    input  logic [pckg_sz-1:0]       tx_data,
    output logic                     tx_full,
    output logic [$clog2(depth):0]   tx_count,
    output logic                     pndng,
    output logic [pckg_sz-1:0]       D_pop,
    input  logic                     pop,
    input  logic                     push,
    input  logic [pckg_sz-1:0]       D_push,
    input  logic                     rx_rd,
    output logic [pckg_sz-1:0]       rx_data,
    output logic                     rx_empty,
    output logic [$clog2(depth):0]   rx_count,
    output logic                     rx_ovf,
    output logic [7:0]               misroute_cnt
);
    logic       tx_empty;
    logic       tx_wr_ok;
    logic       rx_full;
    logic       rx_wr_ok;
    logic       rx_accept;
    logic [7:0] push_dst;
    logic       rx_ovf_q, rx_ovf_d;
    logic [7:0] misroute_q, misroute_d;

    bus_dev_port_fifo #(.W(pckg_sz), .DEPTH(depth)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (tx_wr),
        .wdata (tx_data),
        .rd    (pop),
        .rdata (D_pop),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty),
        .wr_ok (tx_wr_ok)
    );

    bus_dev_port_fifo #(.W(pckg_sz), .DEPTH(depth)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (rx_accept),
        .wdata (D_push),
        .rd    (rx_rd),
        .rdata (rx_data),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty),
        .wr_ok (rx_wr_ok)
    );

    // Destination filter plus sticky overflow and saturating misroute accounting.
    always_comb begin
        push_dst   = D_push[pckg_sz-1 -: 8];
        rx_accept  = push && ((push_dst == dev_id) || (push_dst == broadcast));
        rx_ovf_d   = rx_ovf_q;
        misroute_d = misroute_q;
        if (rx_accept && !rx_wr_ok) begin
            rx_ovf_d = 1'b1;
        end
        if (push && !rx_accept && (misroute_q != 8'hFF)) begin
            misroute_d = misroute_q + 8'd1;
        end
    end

    // Status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ovf_q   <= 1'b0;
            misroute_q <= 8'd0;
        end else begin
            rx_ovf_q   <= rx_ovf_d;
            misroute_q <= misroute_d;
        end
    end

    assign pndng        = !tx_empty;
    assign rx_ovf       = rx_ovf_q;
    assign misroute_cnt = misroute_q;

    // The TX accept strobe is only needed internally by the FIFO.
    logic unused_tx_wr_ok;
    assign unused_tx_wr_ok = tx_wr_ok;
endmodule

// File: tb/tb_bus_dev_port.sv
// Scoreboard bench for bus_dev_port: queue-based reference model, monitor compares on every falling edge.
// Stimulus changes 1 time unit after the rising edge; the model advances at the same rising edge as the DUT.
// Directed phases cover the listed scenarios, followed by randomized traffic with occasional resets.
module tb_bus_dev_port;
    localparam int PS = 20;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          tx_wr;
    logic [PS-1:0] tx_data;
    logic          tx_full;
    logic [3:0]    tx_count;
    logic          pndng;
    logic [PS-1:0] D_pop;
    logic          pop;
    logic          push;
    logic [PS-1:0] D_push;
    logic          rx_rd;
    logic [PS-1:0] rx_data;
    logic          rx_empty;
    logic [3:0]    rx_count;
    logic          rx_ovf;
    logic [7:0]    misroute_cnt;

    always #5 clk = ~clk;

    bus_dev_port #(.pckg_sz(PS), .depth(DP), .dev_id(8'd3), .broadcast(8'hFF)) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_wr        (tx_wr),
        .tx_data      (tx_data),
        .tx_full      (tx_full),
        .tx_count     (tx_count),
        .pndng        (pndng),
        .D_pop        (D_pop),
        .pop          (pop),
        .push         (push),
        .D_push       (D_push),
        .rx_rd        (rx_rd),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .rx_count     (rx_count),
        .rx_ovf       (rx_ovf),
        .misroute_cnt (misroute_cnt)
    );

    int            checks   = 0;
    int            failures = 0;
    bit            mon_en   = 1'b0;
    logic [PS-1:0] tx_m [$];
    logic [PS-1:0] rx_m [$];
    bit            ovf_m;
    int            mis_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, then advance the reference model on the same edge.
    task automatic step(input bit r, input bit w, input logic [PS-1:0] wd, input bit p,
                        input bit ps, input logic [PS-1:0] pd, input bit rd);
        bit       pop_ok, rd_ok, acc;
        bit [7:0] dst;
        reset = r; tx_wr = w; tx_data = wd; pop = p; push = ps; D_push = pd; rx_rd = rd;
        @(posedge clk);
        if (r) begin
            tx_m.delete();
            rx_m.delete();
            ovf_m = 1'b0;
            mis_m = 0;
        end else begin
            pop_ok = p && (tx_m.size() > 0);
            if (pop_ok) void'(tx_m.pop_front());
            if (w && (tx_m.size() < DP)) tx_m.push_back(wd);
            dst   = pd[PS-1:PS-8];
            acc   = ps && (dst == 8'd3 || dst == 8'hFF);
            rd_ok = rd && (rx_m.size() > 0);
            if (rd_ok) void'(rx_m.pop_front());
            if (acc) begin
                if (rx_m.size() < DP) rx_m.push_back(pd);
                else ovf_m = 1'b1;
            end
            if (ps && !acc && mis_m < 255) mis_m++;
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 0, '0, 0);
    endtask

    // Monitor: every falling edge, compare DUT outputs against the scoreboard queues and flags.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("tx_count", 32'(tx_count), 32'(tx_m.size()));
            chk("pndng", 32'(pndng), 32'(tx_m.size() != 0));
            chk("tx_full", 32'(tx_full), 32'(tx_m.size() == DP));
            chk("D_pop", 32'(D_pop), (tx_m.size() != 0) ? 32'(tx_m[0]) : 32'd0);
            chk("rx_count", 32'(rx_count), 32'(rx_m.size()));
            chk("rx_empty", 32'(rx_empty), 32'(rx_m.size() == 0));
            chk("rx_data", 32'(rx_data), (rx_m.size() != 0) ? 32'(rx_m[0]) : 32'd0);
            chk("rx_ovf", 32'(rx_ovf), 32'(ovf_m));
            chk("misroute_cnt", 32'(misroute_cnt), 32'(mis_m));
        end
    end

    initial begin
        logic [31:0]   rnd;
        logic [PS-1:0] d;
        logic [7:0]    dst;

        // Reset values.
        step(1, 0, '0, 0, 0, '0, 0);
        mon_en = 1'b1;
        step(1, 0, '0, 0, 0, '0, 0);
        chk("rst_pndng", 32'(pndng), 0);
        chk("rst_tx_full", 32'(tx_full), 0);
        chk("rst_rx_empty", 32'(rx_empty), 1);
        chk("rst_rx_ovf", 32'(rx_ovf), 0);
        chk("rst_misroute", 32'(misroute_cnt), 0);
        chk("rst_D_pop", 32'(D_pop), 0);
        chk("rst_rx_data", 32'(rx_data), 0);

        // TX fill, dropped 9th write, in-order drain.
        for (int i = 1; i <= 8; i++) step(0, 1, PS'(32'h02000 + i), 0, 0, '0, 0);
        chk("fill_tx_full", 32'(tx_full), 1);
        step(0, 1, 20'h02009, 0, 0, '0, 0);
        chk("fill_drop_count", 32'(tx_count), 8);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_order", 32'(D_pop), 32'h02000 + i);
            step(0, 0, '0, 1, 0, '0, 0);
        end
        chk("drain_pndng", 32'(pndng), 0);
        chk("drain_D_pop", 32'(D_pop), 0);

        // Simultaneous write and pop while full.
        for (int i = 1; i <= 8; i++) step(0, 1, PS'(32'h02010 + i), 0, 0, '0, 0);
        step(0, 1, 20'h030AA, 1, 0, '0, 0);
        chk("simul_count", 32'(tx_count), 8);
        for (int i = 0; i < 7; i++) step(0, 0, '0, 1, 0, '0, 0);
        chk("simul_last", 32'(D_pop), 32'h030AA);
        step(0, 0, '0, 1, 0, '0, 0);
        chk("simul_empty", 32'(pndng), 0);
        // Empty pop together with write: only the write lands.
        step(0, 1, 20'h04444, 1, 0, '0, 0);
        chk("empty_wr_pop", 32'(D_pop), 32'h04444);

        // Mixed TX traffic to exercise pointer wrap.
        for (int i = 0; i < 20; i++) begin
            rnd = $urandom;
            d   = rnd[19:0];
            step(0, rnd[20] | rnd[22], d, rnd[21], 0, '0, 0);
        end
        while (tx_m.size() > 0) step(0, 0, '0, 1, 0, '0, 0);

        // RX filtering.
        step(0, 0, '0, 0, 1, 20'h03123, 0);
        step(0, 0, '0, 0, 1, 20'hFF456, 0);
        step(0, 0, '0, 0, 1, 20'h05789, 0);
        chk("filt_mis", 32'(misroute_cnt), 1);
        chk("filt_count", 32'(rx_count), 2);
        chk("filt_head0", 32'(rx_data), 32'h03123);
        step(0, 0, '0, 0, 0, '0, 1);
        chk("filt_head1", 32'(rx_data), 32'hFF456);
        step(0, 0, '0, 0, 0, '0, 1);
        chk("filt_empty", 32'(rx_empty), 1);
        step(0, 0, '0, 0, 0, '0, 1);

        // RX overflow and misroute saturation.
        for (int i = 1; i <= 9; i++) step(0, 0, '0, 0, 1, PS'(32'h03000 + i), 0);
        chk("ovf_set", 32'(rx_ovf), 1);
        chk("ovf_count", 32'(rx_count), 8);
        for (int i = 0; i < 8; i++) step(0, 0, '0, 0, 0, '0, 1);
        chk("ovf_sticky", 32'(rx_ovf), 1);
        chk("ovf_drained", 32'(rx_empty), 1);
        for (int i = 0; i < 300; i++) begin
            rnd = $urandom;
            step(0, 0, '0, 0, 1, {8'h05, rnd[11:0]}, 0);
        end
        chk("mis_sat", 32'(misroute_cnt), 255);

        // Reset mid-operation with every strobe active.
        step(1, 0, '0, 0, 0, '0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, PS'(32'h06000 + i), 0, 0, '0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 0, 1, PS'(32'h03A00 + i), 0);
        step(1, 1, 20'h0ABCD, 1, 1, 20'h03FFF, 1);
        chk("mid_tx_count", 32'(tx_count), 0);
        chk("mid_rx_count", 32'(rx_count), 0);
        chk("mid_D_pop", 32'(D_pop), 0);
        chk("mid_rx_data", 32'(rx_data), 0);
        idle();
        chk("mid_after_pndng", 32'(pndng), 0);
        chk("mid_after_rx_empty", 32'(rx_empty), 1);

        // Randomized traffic with rare resets.
        for (int i = 0; i < 2000; i++) begin
            rnd = $urandom;
            d   = rnd[19:0];
            case (rnd[25:24])
                2'd0:    dst = 8'd3;
                2'd1:    dst = 8'hFF;
                default: dst = rnd[31:24];
            endcase
            step(($urandom_range(0, 199) == 0), rnd[20], d, rnd[21], rnd[22],
                 {dst, rnd[11:0]}, rnd[23] & rnd[26]);
        end
        idle();

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
